// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and derived constants for the Booth multiplier
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {ZERO, PM, P2M, NM, N2M} booth_op_t;

  // WIDTH+2 extended multiplier bits, two retired per step
  function automatic int calc_steps(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth4_recode.sv
// rtl/booth4_recode.sv - radix-4 Booth recoder: 3-bit window to zero/two/neg flags
module booth4_recode
  import mult_pkg::*;
(
  input  logic [2:0] window,
  output logic       zero,
  output logic       two,
  output logic       neg
);

  booth_op_t op;

  always_comb begin
    op = ZERO;
    case (window)
      3'b001, 3'b010: op = PM;
      3'b011:         op = P2M;
      3'b100:         op = N2M;
      3'b101, 3'b110: op = NM;
      default:        op = ZERO;
    endcase
  end

  assign zero = (op == ZERO);
  assign two  = (op == P2M) || (op == N2M);
  assign neg  = (op == NM) || (op == N2M);

endmodule

// File: rtl/booth4_mult_seq.sv
// rtl/booth4_mult_seq.sv - sequential radix-4 Booth multiplier, signed/unsigned, start/busy/done
module booth4_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = calc_steps(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow
);

  localparam int XW = WIDTH + 2;
  localparam int AW = WIDTH + 3;
  localparam int PW = 2 * WIDTH + 5;
  localparam int CW = $clog2(STEPS);

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      prod_step;
  logic [XW-1:0]      mcand;
  logic               mode_signed;
  logic [XW-1:0]      a_ext, b_ext;
  logic               rec_zero, rec_two, rec_neg;
  logic [AW-1:0]      m_wide, m_mag, addend, sum;
  logic [2*WIDTH-1:0] product;
  logic               ovf_next;
  logic               accept;
  logic               last_step;

  assign a_ext     = {{2{is_signed & operand_a[WIDTH-1]}}, operand_a};
  assign b_ext     = {{2{is_signed & operand_b[WIDTH-1]}}, operand_b};
  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (count == CW'(STEPS - 1));

  booth4_recode u_recode (
    .window (prod[2:0]),
    .zero   (rec_zero),
    .two    (rec_two),
    .neg    (rec_neg)
  );

  // Accumulator is sign-extended one bit so +/-2M can never overflow the adder
  always_comb begin
    m_wide    = {mcand[XW-1], mcand};
    m_mag     = rec_two ? {m_wide[AW-2:0], 1'b0} : m_wide;
    addend    = rec_zero ? '0 : (rec_neg ? (~m_mag + AW'(1)) : m_mag);
    sum       = {prod[PW-1], prod[PW-1:XW+1]} + addend;
    prod_step = {sum[AW-1], sum, prod[XW:2]};
    product   = prod_step[2*WIDTH:1];
    ovf_next  = mode_signed
              ? !((&product[2*WIDTH-1:WIDTH-1]) || !(|product[2*WIDTH-1:WIDTH-1]))
              : (|product[2*WIDTH-1:WIDTH]);
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (count == CW'(STEPS - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prod        <= '0;
      mcand       <= '0;
      mode_signed <= 1'b0;
      count       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      overflow    <= 1'b0;
    end else if (accept) begin
      prod        <= {XW'(0), b_ext, 1'b0};
      mcand       <= a_ext;
      mode_signed <= is_signed;
      count       <= '0;
    end else if (state == RUN) begin
      prod  <= prod_step;
      count <= count + CW'(1);
      if (last_step) begin
        result_lo <= product[WIDTH-1:0];
        result_hi <= product[2*WIDTH-1:WIDTH];
        overflow  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_booth4_mult_seq.sv
// tb/tb_booth4_mult_seq.sv - directed self-checking bench for booth4_mult_seq at WIDTH 32 and 8
module tb_booth4_mult_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        start32, sgn32, busy32, done32, ov32;
  logic [31:0] a32, b32, lo32, hi32;
  logic        start8, sgn8, busy8, done8, ov8;
  logic [7:0]  a8, b8, lo8, hi8;

  int checks   = 0;
  int failures = 0;

  logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80,
                            8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h13};

  booth4_mult_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .resetn(resetn), .start(start32), .is_signed(sgn32),
    .operand_a(a32), .operand_b(b32), .busy(busy32), .done(done32),
    .result_lo(lo32), .result_hi(hi32), .overflow(ov32)
  );

  booth4_mult_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .resetn(resetn), .start(start8), .is_signed(sgn8),
    .operand_a(a8), .operand_b(b8), .busy(busy8), .done(done8),
    .result_lo(lo8), .result_hi(hi8), .overflow(ov8)
  );

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      output int lat, output logic [31:0] lo, output logic [31:0] hi,
                      output logic ov);
    @(posedge clock); #1;
    a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done32) begin lat = i; break; end
    end
    lo = lo32; hi = hi32; ov = ov32;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit scramble,
                     output int lat, output logic [15:0] p, output logic ov);
    @(posedge clock); #1;
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      end
      @(posedge clock); #1;
      if (done8) begin lat = i; break; end
    end
    p = {hi8, lo8}; ov = ov8;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
    start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy32, done32, ov32, lo32, hi32} !== 67'd0) begin
      failures++;
      $display("FAIL reset32 got busy=%b done=%b ov=%b lo=%h hi=%h expected all 0",
               busy32, done32, ov32, lo32, hi32);
    end
    checks++;
    if ({busy8, done8, ov8, lo8, hi8} !== 19'd0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b ov=%b lo=%h hi=%h expected all 0",
               busy8, done8, ov8, lo8, hi8);
    end
    resetn = 1'b1;
  endtask

  task automatic test_signed_basic();
    int lat; logic [31:0] lo, hi; logic ov;
    op32(32'd7, 32'hFFFFFFFD, 1'b1, lat, lo, hi, ov);
    checks++;
    if (lat != 17) begin failures++; $display("FAIL lat32 got=%0d expected=17", lat); end
    checks++;
    if ({hi, lo, ov} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}) begin
      failures++;
      $display("FAIL s7x-3 got hi=%h lo=%h ov=%b expected FFFFFFFF FFFFFFEB 0", hi, lo, ov);
    end
  endtask

  task automatic test_all_ones();
    int lat; logic [31:0] lo, hi; logic ov;
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, lo, hi, ov);
    checks++;
    if ({hi, lo, ov} !== {32'hFFFFFFFE, 32'h00000001, 1'b1}) begin
      failures++;
      $display("FAIL u_ones got hi=%h lo=%h ov=%b expected FFFFFFFE 00000001 1", hi, lo, ov);
    end
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, lo, hi, ov);
    checks++;
    if ({hi, lo, ov} !== {32'h00000000, 32'h00000001, 1'b0}) begin
      failures++;
      $display("FAIL s_ones got hi=%h lo=%h ov=%b expected 00000000 00000001 0", hi, lo, ov);
    end
  endtask

  task automatic test_most_negative();
    int lat; logic [31:0] lo, hi; logic ov;
    op32(32'h80000000, 32'h80000000, 1'b1, lat, lo, hi, ov);
    checks++;
    if ({hi, lo, ov} !== {32'h40000000, 32'h00000000, 1'b1}) begin
      failures++;
      $display("FAIL s_minxmin got hi=%h lo=%h ov=%b expected 40000000 00000000 1", hi, lo, ov);
    end
    op32(32'h80000000, 32'h00000001, 1'b1, lat, lo, hi, ov);
    checks++;
    if ({hi, lo, ov} !== {32'hFFFFFFFF, 32'h80000000, 1'b0}) begin
      failures++;
      $display("FAIL s_minx1 got hi=%h lo=%h ov=%b expected FFFFFFFF 80000000 0", hi, lo, ov);
    end
  endtask

  task automatic test_w8_sweep();
    int lat, ea, eb, pr;
    logic [15:0] p, exp_p;
    logic ov, exp_ov;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 12; i++) begin
        for (int j = 0; j < 12; j++) begin
          op8(vals[i], vals[j], 1'(s), ((i + j) % 3) == 0, lat, p, ov);
          ea = (s == 1) ? {{24{vals[i][7]}}, vals[i]} : {24'd0, vals[i]};
          eb = (s == 1) ? {{24{vals[j][7]}}, vals[j]} : {24'd0, vals[j]};
          pr = ea * eb;
          exp_p  = pr[15:0];
          exp_ov = (s == 1) ? (pr < -128 || pr > 127) : (pr > 255);
          if (s == 0 && i == 4 && j == 5) begin
            checks++;
            if (lat != 5) begin failures++; $display("FAIL lat8 got=%0d expected=5", lat); end
          end
          checks++;
          if (p !== exp_p || ov !== exp_ov) begin
            failures++;
            $display("FAIL w8 s=%0d a=%h b=%h got p=%h ov=%b lat=%0d expected p=%h ov=%b",
                     s, vals[i], vals[j], p, ov, lat, exp_p, exp_ov);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int last  = -1;
    @(posedge clock); #1;
    a8 = 8'h9C; b8 = 8'h07; sgn8 = 1'b1; start8 = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clock); #1;
      if (done8) begin
        checks++;
        if ({hi8, lo8, ov8} !== {16'hFD44, 1'b1}) begin
          failures++;
          $display("FAIL b2b_result got p=%h ov=%b expected FD44 1", {hi8, lo8}, ov8);
        end
        if (dones > 0) begin
          checks++;
          if (cyc - last != 6) begin
            failures++;
            $display("FAIL b2b_gap got=%0d expected=6", cyc - last);
          end
        end
        last = cyc;
        dones++;
        if (dones == 3) begin start8 = 1'b0; break; end
      end
    end
    start8 = 1'b0;
    checks++;
    if (dones != 3) begin failures++; $display("FAIL b2b_count got=%0d expected=3", dones); end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    @(posedge clock); #1;
    a8 = 8'h0D; b8 = 8'h0B; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clock); #1;
      if (done8) begin
        dones++;
        checks++;
        if ({hi8, lo8, ov8} !== {16'h008F, 1'b0}) begin
          failures++;
          $display("FAIL ignore_result got p=%h ov=%b expected 008F 0", {hi8, lo8}, ov8);
        end
      end
      if (cyc == 1 || cyc == 3) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        start8 = 1'b0;
      end
    end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL ignore_count got=%0d expected=1", dones); end
  endtask

  task automatic test_reset_mid_run();
    int lat, seen = 0;
    logic [31:0] lo, hi; logic ov;
    @(posedge clock); #1;
    a32 = 32'h12345678; b32 = 32'd3; sgn32 = 1'b0; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (7) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy32, done32, ov32, lo32, hi32} !== 67'd0) begin
      failures++;
      $display("FAIL async_reset got busy=%b done=%b ov=%b lo=%h hi=%h expected all 0",
               busy32, done32, ov32, lo32, hi32);
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      if (done32 || busy32) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL no_done_after_reset got=%0d expected=0", seen); end
    op32(32'd5, 32'd5, 1'b0, lat, lo, hi, ov);
    checks++;
    if ({hi, lo, ov} !== {32'd0, 32'd25, 1'b0} || lat != 17) begin
      failures++;
      $display("FAIL post_reset_5x5 got hi=%h lo=%h ov=%b lat=%0d expected 0 25 0 17",
               hi, lo, ov, lat);
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_all_ones();
    test_most_negative();
    test_w8_sweep();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth4_mult_seq.md
Name: booth4_mult_seq

Overview:
- Parametrised sequential radix-4 Booth multiplier.
- It is the next-generation MultDiv multiplier, used by the CPU's mult/div unit.
- Adds over the previous generation:
  - generic operand width
  - signed/unsigned mode select
  - full 2*WIDTH product output
  - explicit start/busy/done handshake
  - asynchronous reset
- One Booth step retires two multiplier bits per clock.

Parameters:
- WIDTH, 32: operand width. Must be even and >= 4.
- STEPS, WIDTH/2+1: number of Booth iterations, derived. Do not override.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when not busy
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- operand_a  in  WIDTH  multiplicand; captured with start
- operand_b  in  WIDTH  multiplier; captured with start
- busy  out  1  high from the accepting edge until the edge that enters DONE
- done  out  1  one-cycle pulse; result valid
- result_lo  out  WIDTH  product bits [WIDTH-1:0]
- result_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]
- overflow  out  1  product not representable in WIDTH bits under the captured mode

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, step counter=0, all registers cleared.
  - busy=0, done=0, result_lo=0, result_hi=0, overflow=0.
  - Reset mid-operation aborts the operation silently; no done pulse follows.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE when the counter reaches STEPS-1 (on that step's edge).
  - DONE -> RUN if start=1, giving back-to-back operation; otherwise DONE -> IDLE.
- Capture on the accepting edge:
  - Operands are extended to WIDTH+2 bits: sign-extended if is_signed=1, else zero-extended.
  - Product register (2*WIDTH+5 bits) = {upper 0, extended B, 1'b0}.
  - Multiplicand register = extended A. Mode is latched.
- Each RUN edge:
  - Recode product register bits [2:0] as 0, +M, +2M, -M, -2M (standard radix-4 Booth table).
  - Add the recoded value to the upper WIDTH+3 bits using a WIDTH+3-bit adder. Sign-extending the accumulator into the extra bit means no overflow handling is needed.
  - Arithmetic-shift the whole register right by 2.
  - Counter increments.
- Latency: if start is accepted at edge E, done=1 in the cycle after edge E+STEPS. For WIDTH=32 that is 17 cycles.
- start while busy is ignored; operand and mode changes during RUN have no effect.
- Result and overflow registers:
  - Load on the edge entering DONE.
  - Hold through IDLE until the next DONE.
  - The next start does not clear them.
- Overflow rule:
  - Signed: product bits [2*WIDTH-1:WIDTH-1] not all equal.
  - Unsigned: result_hi != 0.
- Corner values must produce exact products with no special-casing: zero, all-ones, and the most-negative value, e.g. -2^(W-1) * -2^(W-1) signed.

Decomposition:
- Package mult_pkg holds:
  - state typedef {IDLE, RUN, DONE}
  - booth op typedef {ZERO, PM, P2M, NM, N2M}
  - function computing STEPS from WIDTH
- Sub-module booth4_recode: 3-bit window -> {zero, two, neg} flags, purely combinational.
- The adder is inline or the existing alu-style adder generalised to WIDTH+3 bits.
- The counter is local, clog2(STEPS) bits.

Test Plan:
1. WIDTH=32, signed: 7 * -3 -> done exactly 17 cycles after the accept edge; result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF, overflow=0.
2. WIDTH=32, unsigned: 0xFFFFFFFF * 0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, overflow=1. The same operands signed give hi=0, lo=1, overflow=0.
3. WIDTH=32, signed: 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0, overflow=1. 0x80000000 * 1 -> overflow=0.
4. WIDTH=8:
   - Exhaustive 256x256 in both modes against a reference model.
   - Done comes 5 cycles after accept.
   - Operands toggled randomly during RUN must not affect the result.
5. Handshake:
   - start held high continuously gives back-to-back ops, with done every STEPS+1 cycles.
   - start pulsed while busy is ignored: exactly one done per accepted start.
6. resetn deasserted asynchronously mid-RUN (cycle 8 of 17) -> all outputs 0 immediately, no done. After release, a new 5*5 op returns 25.
